gnr_cycle_detect: RTL and testbench
===================================

GNR_CYCLE_DETECT -- requirements
Module: gnr_cycle_detect

Interface
REQ-001 Parameter N, default 8, is the number of network nodes, which is also the state vector width.
REQ-002 Parameter CW, default 16, is the step counter width.
REQ-003 Parameter MAX_STEPS, default 1024, is the hare-step budget per initial state (1 <= MAX_STEPS < 2^CW).
REQ-004 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  begin a sweep; sampled only in IDLE.
REQ-007 init_first  in  N  first initial state of the sweep; latched on accepted start.
REQ-008 init_last  in  N  last initial state of the sweep; latched on accepted start.
REQ-009 s0_in  in  N  tortoise state vector, concatenated node s0 outputs.
REQ-010 s1_in  in  N  hare state vector, concatenated node s1 outputs.
REQ-011 reset_nos  out  1  load init_state into every node.
REQ-012 start_s0  out  1  tortoise step enable (nodes advance on every second pulse).
REQ-013 start_s1  out  1  hare step enable (nodes advance on every pulse).
REQ-014 init_state  out  N  current initial state; bit i drives node i.
REQ-015 res_valid  out  1  result available.
REQ-016 res_ready  in  1  result consumed.
REQ-017 res_init  out  N  initial state the result belongs to.
REQ-018 res_steps  out  CW  hare steps issued before the meet or the timeout.
REQ-019 res_state  out  N  s1_in captured at the meet (a state on the attractor).
REQ-020 res_timeout  out  1  the budget was exhausted without a meet.
REQ-021 busy  out  1  high in every state except IDLE.
REQ-022 done  out  1  one-cycle pulse when the sweep completes.

Function
REQ-023 The FSM SHALL have the states IDLE, LOAD, RUN, EMIT, NEXT and FIN.
REQ-024 IDLE: when start is high, latch init_first/init_last, set cur=init_first and go to LOAD; start SHALL be ignored in every other state.
REQ-025 LOAD: assert reset_nos for exactly one cycle with init_state=cur, clear the step counter, then go to RUN.
REQ-026 RUN: start_s0=start_s1=1 combinationally unless meet or timeout is true in the same cycle; steps increments on every cycle in which the starts are asserted.
REQ-027 meet SHALL be defined as (steps != 0) && (s0_in == s1_in); steps==0 masks the trivial equality right after LOAD.
REQ-028 On meet: capture res_init=cur, res_steps=steps, res_state=s1_in and res_timeout=0, then go to EMIT.
REQ-029 Timeout SHALL be defined as steps==MAX_STEPS without meet: capture res_steps=MAX_STEPS, res_timeout=1 and res_state=s1_in, then go to EMIT; meet SHALL take priority over timeout in the same cycle.
REQ-030 EMIT: res_valid=1, and all res_* SHALL stay stable until res_ready; on res_valid&&res_ready go to NEXT; no start pulses are issued.
REQ-031 NEXT: if cur==init_last go to FIN, else cur=cur+1 modulo 2^N and go to LOAD.
REQ-032 Wrap-around is legal: init_last<init_first sweeps through 2^N-1 and then 0.
REQ-033 init_first==init_last SHALL produce exactly one result.
REQ-034 FIN: done=1 for one cycle, then go to IDLE.
REQ-035 reset_nos, start_s0 and start_s1 SHALL never be high in the same cycle.
REQ-036 Result throughput: one result per initial state, delivered in order.

Reset
REQ-037 On rst the block SHALL enter IDLE, and reset_nos, start_s0, start_s1, res_valid, done, busy, res_timeout, res_init, res_state, res_steps, init_state, cur and steps SHALL all be 0.
REQ-038 rst SHALL abort any state mid-operation within the same cycle; any pending result is discarded.

Verification
REQ-039 Identity network (next=x), N=8, first=last=0x05 -> reset_nos for 1 cycle, one start pulse, then res_valid with res_steps=1, res_state=0x05, res_timeout=0, followed by a done pulse.
REQ-040 Network next=x+1 mod 256, MAX_STEPS=16, first=last=0 -> res_timeout=1, res_steps=16, exactly 16 start_s1 pulses.
REQ-041 Constant network (next=0xAA), first=0x00, last=0x02 -> three results in order with res_init 0x00, 0x01, 0x02, each with res_state=0xAA, then done.
REQ-042 Wrap sweep first=0xFE, last=0x01 -> res_init sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-043 Back-pressure: hold res_ready=0 for 10 cycles -> res_* stable, no reset_nos or start pulses issued, and the next LOAD occurs only after the handshake.
REQ-044 rst asserted during RUN -> all outputs 0 next cycle; a new start then restarts cleanly from init_first.

Source files
------------

// File: rtl/gnr_cycle_detect.sv
// Floyd-style cycle detector driving a Boolean network of N nodes.
// For every initial state in [init_first .. init_last] (with wrap-around) the
// nodes are loaded, then tortoise (s0) and hare (s1) are stepped until they
// meet or the step budget runs out. One result is emitted per initial state.
module gnr_cycle_detect #(
  parameter int N         = 8,
  parameter int CW        = 16,
  parameter int MAX_STEPS = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  init_first,
  input  logic [N-1:0]  init_last,
  input  logic [N-1:0]  s0_in,
  input  logic [N-1:0]  s1_in,
  output logic          reset_nos,
  output logic          start_s0,
  output logic          start_s1,
  output logic [N-1:0]  init_state,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_init,
  output logic [CW-1:0] res_steps,
  output logic [N-1:0]  res_state,
  output logic          res_timeout,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, EMIT, NEXT, FIN} state_t;

  localparam logic [CW-1:0] MAX_C  = CW'(MAX_STEPS);
  localparam logic [CW-1:0] STEP1  = CW'(1);
  localparam logic [N-1:0]  ONE_N  = N'(1);

  state_t        state, state_nx;
  logic [N-1:0]  cur, last_st;
  logic [CW-1:0] steps;
  logic          meet, tmo, step_en;

  // steps==0 hides the trivial s0==s1 right after the nodes were loaded
  assign meet = (steps != '0) && (s0_in == s1_in);
  assign tmo  = (steps == MAX_C) && !meet;

  assign start_s0   = step_en;
  assign start_s1   = step_en;
  assign init_state = cur;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state and per-state control outputs
  always_comb begin
    state_nx  = state;
    reset_nos = 1'b0;
    step_en   = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        reset_nos = 1'b1;
        state_nx  = RUN;
      end
      RUN: begin
        if (meet || tmo) state_nx = EMIT;
        else             step_en  = 1'b1;
      end
      EMIT: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = NEXT;
      end
      NEXT: begin
        state_nx = (cur == last_st) ? FIN : LOAD;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // sweep bookkeeping, step counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= '0;
      last_st     <= '0;
      steps       <= '0;
      res_init    <= '0;
      res_steps   <= '0;
      res_state   <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cur     <= init_first;
          last_st <= init_last;
        end
        LOAD: steps <= '0;
        RUN: begin
          if (meet) begin
            res_init    <= cur;
            res_steps   <= steps;
            res_state   <= s1_in;
            res_timeout <= 1'b0;
          end else if (tmo) begin
            res_init    <= cur;
            res_steps   <= MAX_C;
            res_state   <= s1_in;
            res_timeout <= 1'b1;
          end else begin
            steps <= steps + STEP1;
          end
        end
        // modulo-2^N increment gives the wrap-around sweep for free
        NEXT: if (cur != last_st) cur <= cur + ONE_N;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gnr_cycle_detect.sv
// Directed bench for gnr_cycle_detect with a behavioural node network.
module tb_gnr_cycle_detect;

  logic        clk = 1'b0;
  logic        rst, start, res_ready;
  logic [7:0]  init_first, init_last;
  logic [7:0]  s0, s1;
  logic        ph;
  logic        reset_nos, start_s0, start_s1, res_valid, res_timeout, busy, done;
  logic [7:0]  init_state, res_init, res_state;
  logic [15:0] res_steps;

  int total = 0;
  int bad   = 0;
  int n_rn  = 0;
  int n_s1  = 0;
  int n_ovl = 0;
  int mode  = 0;  // 0 identity, 1 x+1, 2 constant 0xAA

  gnr_cycle_detect #(.N(8), .CW(16), .MAX_STEPS(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .init_first(init_first), .init_last(init_last),
    .s0_in(s0), .s1_in(s1),
    .reset_nos(reset_nos), .start_s0(start_s0), .start_s1(start_s1),
    .init_state(init_state), .res_valid(res_valid), .res_ready(res_ready),
    .res_init(res_init), .res_steps(res_steps), .res_state(res_state),
    .res_timeout(res_timeout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] nxt(input logic [7:0] x);
    case (mode)
      0:       nxt = x;
      1:       nxt = x + 8'd1;
      default: nxt = 8'hAA;
    endcase
  endfunction

  // network model: hare steps every pulse, tortoise every second pulse
  always @(posedge clk) begin
    if (reset_nos) begin
      s0 <= init_state;
      s1 <= init_state;
      ph <= 1'b0;
    end else begin
      if (start_s1) s1 <= nxt(s1);
      if (start_s0) begin
        ph <= ~ph;
        if (ph) s0 <= nxt(s0);
      end
    end
    if (reset_nos) n_rn <= n_rn + 1;
    if (start_s1)  n_s1 <= n_s1 + 1;
    if (reset_nos && (start_s0 || start_s1)) n_ovl <= n_ovl + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [7:0] f, input logic [7:0] l);
    @(negedge clk);
    init_first = f;
    init_last  = l;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int i = 0;
    while (!res_valid && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_vld"}, {31'd0, res_valid}, 32'd1);
  endtask

  task automatic take(input string tag, input logic [7:0] ei, input logic [15:0] es,
                      input logic [7:0] est, input logic eto);
    wait_valid(tag);
    chk({tag, "_init"},  {24'd0, res_init},    {24'd0, ei});
    chk({tag, "_steps"}, {16'd0, res_steps},   {16'd0, es});
    chk({tag, "_state"}, {24'd0, res_state},   {24'd0, est});
    chk({tag, "_to"},    {31'd0, res_timeout}, {31'd0, eto});
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic finish_sweep(input string tag);
    int i = 0;
    while (!done && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    @(negedge clk);
    chk({tag, "_done1"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"},  {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int rn0, s10;
    logic [7:0]  hi, hst;
    logic [15:0] hs;
    rst = 1'b1; start = 1'b0; res_ready = 1'b0;
    init_first = '0; init_last = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_pulse", {29'd0, reset_nos, start_s0, start_s1}, 32'd0);
    chk("rst_res",   {res_valid, res_timeout, done, res_init, res_state, res_steps}, 32'd0);
    chk("rst_init",  {24'd0, init_state}, 32'd0);
    rst = 1'b0;

    // identity network: single step then meet
    mode = 0; rn0 = n_rn; s10 = n_s1;
    kick(8'h05, 8'h05);
    chk("id_load", {31'd0, reset_nos}, 32'd1);
    chk("id_ist",  {24'd0, init_state}, 32'h05);
    take("id", 8'h05, 16'd1, 8'h05, 1'b0);
    chk("id_nrn", n_rn - rn0, 32'd1);
    chk("id_ns1", n_s1 - s10, 32'd1);
    finish_sweep("id");

    // x+1 network never meets: budget of 16
    mode = 1; s10 = n_s1;
    kick(8'h00, 8'h00);
    take("inc", 8'h00, 16'd16, 8'h10, 1'b1);
    chk("inc_ns1", n_s1 - s10, 32'd16);
    finish_sweep("inc");

    // constant network: meet after two hare steps
    mode = 2; rn0 = n_rn;
    kick(8'h00, 8'h02);
    for (int i = 0; i < 3; i++) take("cst", 8'(i), 16'd2, 8'hAA, 1'b0);
    chk("cst_nrn", n_rn - rn0, 32'd3);
    finish_sweep("cst");

    // wrap-around sweep
    kick(8'hFE, 8'h01);
    take("wr0", 8'hFE, 16'd2, 8'hAA, 1'b0);
    take("wr1", 8'hFF, 16'd2, 8'hAA, 1'b0);
    take("wr2", 8'h00, 16'd2, 8'hAA, 1'b0);
    take("wr3", 8'h01, 16'd2, 8'hAA, 1'b0);
    finish_sweep("wr");

    // back-pressure: result held, network idle
    kick(8'h10, 8'h11);
    wait_valid("bp");
    hi = res_init; hs = res_steps; hst = res_state;
    rn0 = n_rn; s10 = n_s1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!res_valid || res_init !== hi || res_steps !== hs || res_state !== hst)
        chk("bp_hold", {res_valid, res_init, res_steps, res_state[6:0]},
                       {1'b1, hi, hs, hst[6:0]});
    end
    chk("bp_vld", {31'd0, res_valid}, 32'd1);
    chk("bp_ini", {24'd0, res_init}, 32'h10);
    chk("bp_nrn", n_rn - rn0, 32'd0);
    chk("bp_ns1", n_s1 - s10, 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    take("bp2", 8'h11, 16'd2, 8'hAA, 1'b0);
    chk("bp_nrn2", n_rn - rn0, 32'd1);
    finish_sweep("bp");

    // reset in the middle of a run
    mode = 1;
    kick(8'h40, 8'h40);
    repeat (4) @(negedge clk);
    chk("ab_run", {31'd0, start_s1}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("ab_ctl", {27'd0, busy, reset_nos, start_s0, start_s1, res_valid}, 32'd0);
    chk("ab_res", {res_init, res_steps, res_state}, 32'd0);
    chk("ab_ist", {24'd0, init_state}, 32'd0);
    rst = 1'b0;
    mode = 0;
    kick(8'h33, 8'h33);
    take("ab2", 8'h33, 16'd1, 8'h33, 1'b0);
    finish_sweep("ab2");

    chk("overlap", n_ovl, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
